mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator-side memory controller for the multicycle MIPS datapath.
- Accepts one load/store request at a time from the datapath and checks size, alignment and region.
- Drives the memory-system port (address, write enable, write data) and collects read data.
- Returns sign- or zero-extended load data; performs read-modify-write for byte/halfword stores.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, byte address width
TEXT_BASE, 32'h0040_0000, base of read-only text (ROM) region
DATA_BASE, 32'h1001_0000, base of read/write data (RAM) region
MEMORY_DEPTH, 64, words per region
RD_LAT, 1, cycles from mem_addr_o valid to mem_rdata_i valid (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
req_i  in  1  request strobe, sampled only in IDLE
we_i  in  1  1=store, 0=load
size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
sext_i  in  1  loads: 1 sign-extend, 0 zero-extend
addr_i  in  ADDR_WIDTH  byte address
wdata_i  in  DATA_WIDTH  store data, right-justified
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o; 1 = request rejected
rdata_o  out  DATA_WIDTH  load result, held until next load completes
mem_addr_o  out  ADDR_WIDTH  word-aligned address to memory system
mem_we_o  out  1  memory write enable
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including mem_we_o.
- Reset mid-transaction aborts with no done_o pulse. A pending write is not issued.
- FSM states: IDLE, RD, WR, DONE.
- Accept: in IDLE with req_i=1 at a rising edge. addr/size/we/sext/wdata are registered. req_i is ignored in every other state, including DONE.
- Checks on accept, any failure goes IDLE->DONE with err_o=1:
  - size_i=11 is illegal.
  - Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
  - Unmapped: addr outside [TEXT_BASE, TEXT_BASE+4*MEMORY_DEPTH) and outside [DATA_BASE, DATA_BASE+4*MEMORY_DEPTH).
  - Store to the text region.
  - On error: no memory write occurs and rdata_o is unchanged.
- mem_addr_o = {addr[31:2],2'b00}, driven from the RD/WR entry cycle onward. Held after the transaction.
- Load: IDLE->RD. Stay in RD for RD_LAT cycles (counter). On the last RD cycle, capture mem_rdata_i, extract the lane and extend into rdata_o, then go to DONE.
- Lane extraction is little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1]
- Word store: IDLE->WR. mem_we_o=1 for exactly one cycle with mem_wdata_o=wdata. Then DONE.
- Sub-word store: IDLE->RD (RD_LAT cycles, capture old word)->WR. In WR the byte/half is merged into the selected lane, the other lanes are preserved, and the write is issued. Then DONE.
- DONE: done_o=1 for one cycle, err_o valid, then IDLE. err_o=0 for successful operations.
- Latency from the accept edge to done_o high:
  - load: RD_LAT+1 cycles
  - word store: 2 cycles
  - sub-word store: RD_LAT+2 cycles
  - error: 1 cycle
- mem_we_o is never high outside WR.
- Back-to-back: the earliest next accept is the IDLE cycle following DONE.

Decomposition:
- Package mem_access_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state_t enum (IDLE, RD, WR, DONE)
  - TEXT_BASE/DATA_BASE defaults
  - region-decode and alignment-check functions
- Sub-module mem_lane_align: combinational lane extract with sign/zero extend, and lane merge for stores. This keeps the FSM file free of datapath muxing.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x1001_0004, then load word @0x1001_0004.
  - Store: mem_we_o high exactly 1 cycle, mem_addr_o=0x1001_0004, done_o 2 cycles after accept.
  - Load: rdata_o=0xDEADBEEF, done_o RD_LAT+1 cycles after accept, err_o=0.
- Byte RMW: RAM word @0x1001_0008 = 0x1122_3344; store byte 0xAA @0x1001_000A.
  - Exactly one write of 0x11AA_3344.
  - Load byte sext=1 @0x1001_000A -> 0xFFFF_FFAA; sext=0 -> 0x0000_00AA.
- Half load @0x1001_0008 (data 0x8001_7FFF): sext=1 -> 0x0000_7FFF; @0x1001_000A sext=1 -> 0xFFFF_8001.
- Errors, each giving done_o=1, err_o=1 one cycle after accept, mem_we_o never asserted, rdata_o unchanged:
  - word load @0x1001_0002
  - store @0x0040_0000
  - load @0x2000_0000
  - size_i=11
- ROM read: load word @0x0040_0008 -> rdata_o equals the preloaded ROM word, err_o=0. req_i held high during busy -> exactly one transaction per IDLE accept.
- Reset mid-op: assert rst_i during WR of a sub-word store -> mem_we_o drops immediately, no done_o pulse, RAM word unchanged, next request completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and address-check helpers for the MIPS data-memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [31:0] TEXT_BASE_DEF = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;

  // Offset form avoids overflow of base + span near the top of the address space.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
    logic [31:0] off_s;
    off_s = addr - base;
    return (addr >= base) && (off_s < 32'(depth * 32'd4));
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] lane);
    logic bad_s;
    case (size)
      SZ_HALF: bad_s = lane[0];
      SZ_WORD: bad_s = (lane != 2'b00);
      default: bad_s = 1'b0;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane extract with sign/zero extension, and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [1:0]    lane,
  input  logic [DW-1:0] rword,
  input  logic [15:0]   wdata,
  output logic [DW-1:0] load_val,
  output logic [DW-1:0] merge_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, extend it for loads and splice store data into it.
  always_comb begin
    load_val   = rword;
    merge_word = rword;
    byte_s     = rword[{lane, 3'b000} +: 8];
    half_s     = rword[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        load_val = {{(DW-8){sext & byte_s[7]}}, byte_s};
        merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{(DW-16){sext & half_s[15]}}, half_s};
        merge_word[{lane[1], 4'b0000} +: 16] = wdata;
      end
      default: begin
        load_val   = rword;
        merge_word = rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the multicycle MIPS datapath and the memory system.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] TEXT_BASE    = TEXT_BASE_DEF,
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEF,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    we_r, sext_r;
  logic [1:0]              size_r, lane_r;
  logic [15:0]             wdata_r;
  logic                    busy_r, done_r, err_r, mem_we_r;
  logic [DATA_WIDTH-1:0]   rdata_r, mem_wdata_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic                    in_text_s, in_data_s, chk_err_s;
  logic [DATA_WIDTH-1:0]   load_val_s, merge_word_s;

  // Request legality: size, alignment, region mapping and text write-protect.
  always_comb begin
    in_text_s = in_region(addr_i, TEXT_BASE, MEMORY_DEPTH);
    in_data_s = in_region(addr_i, DATA_BASE, MEMORY_DEPTH);
    chk_err_s = (size_i == 2'b11) || misaligned(size_i, addr_i[1:0]) ||
                !(in_text_s || in_data_s) || (we_i && in_text_s);
  end

  // Next-state logic; only word stores skip the read phase.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          if (chk_err_s) begin
            state_nx_s = DONE;
          end else if (we_i && (size_i == SZ_WORD)) begin
            state_nx_s = WR;
          end else begin
            state_nx_s = RD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (we_r) begin
            state_nx_s = WR;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = RD;
        end
      end
      WR:      state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Status and memory-port outputs follow the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      busy_r   <= (state_nx_s != IDLE);
      done_r   <= (state_nx_s == DONE);
      err_r    <= (state_r == IDLE) && req_i && chk_err_s;
      mem_we_r <= (state_nx_s == WR);
    end
  end

  // Request capture, read-latency counter and datapath result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r       <= {CNT_W{1'b0}};
      we_r        <= 1'b0;
      sext_r      <= 1'b0;
      size_r      <= 2'b00;
      lane_r      <= 2'b00;
      wdata_r     <= 16'h0000;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i) begin
            we_r    <= we_i;
            sext_r  <= sext_i;
            size_r  <= size_i;
            lane_r  <= addr_i[1:0];
            wdata_r <= wdata_i[15:0];
            cnt_r   <= CNT_W'(RD_LAT - 1);
            if (!chk_err_s) begin
              mem_addr_r  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_r <= wdata_i;
            end
          end
        end
        RD: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            if (we_r) begin
              mem_wdata_r <= merge_word_s;
            end else begin
              rdata_r <= load_val_s;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  mem_lane_align #(
    .DW(DATA_WIDTH)
  ) u_lane_align (
    .size      (size_r),
    .sext      (sext_r),
    .lane      (lane_r),
    .rword     (mem_rdata_i),
    .wdata     (wdata_r),
    .load_val  (load_val_s),
    .merge_word(merge_word_s)
  );

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign rdata_o     = rdata_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_we_o    = mem_we_r;
  assign mem_wdata_o = mem_wdata_r;

endmodule
